// File: rtl/signed_mult_seq.sv
// Sequential WIDTH x WIDTH two's-complement multiplier.
// Handshake: start is accepted in IDLE, busy covers ABS/LOOP/SIGN, done pulses for one cycle.
// Internally the operands are converted to magnitudes, multiplied by unsigned shift-add
// (one multiplier bit per cycle), and the result is negated when the operand signs differ.
module signed_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multA,
  input  logic [WIDTH-1:0]     multB,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_LOOP,
    S_SIGN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;   // multiplicand, widened so it can shift left
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, consumed LSB first
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic [PW-1:0]   prod_q, prod_d;

  logic [WIDTH-1:0] mcand_neg;
  logic [WIDTH-1:0] mplier_neg;

  assign mcand_neg  = ~mcand_q[WIDTH-1:0] + WIDTH'(1);
  assign mplier_neg = ~mplier_q + WIDTH'(1);
  assign product    = prod_q;

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      prod_q   <= prod_d;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    prod_d   = prod_q;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, multA};
          mplier_d = multB;
          sign_d   = multA[WIDTH-1] ^ multB[WIDTH-1];
          state_d  = S_ABS;
        end
      end

      S_ABS: begin
        busy = 1'b1;
        // Most negative input negates to itself, which read as unsigned is the correct magnitude.
        if (mcand_q[WIDTH-1]) mcand_d = {{WIDTH{1'b0}}, mcand_neg};
        if (mplier_q[WIDTH-1]) mplier_d = mplier_neg;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_LOOP;
      end

      S_LOOP: begin
        busy = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_SIGN;
      end

      S_SIGN: begin
        busy    = 1'b1;
        prod_d  = sign_q ? (~acc_q + PW'(1)) : acc_q;
        state_d = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_signed_mult_seq.sv
// Randomized self-checking bench for signed_mult_seq with an arithmetic reference model.
module tb_signed_mult_seq;

  localparam int unsigned WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   multA = '0;
  logic [WIDTH-1:0]   multB = '0;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_prod = '0;

  signed_mult_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .multA   (multA),
    .multB   (multB),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed product of two 8-bit two's-complement values, 16-bit result.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
  endfunction

  // Full transaction; optionally re-pulse start at cycle 4 with other operands.
  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input bit interfere);
    logic [15:0] exp;
    exp   = model(a, b);
    multA = a;
    multB = b;
    start = 1'b1;
    step();                       // accepting edge 0
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      multA = 8'($urandom);
      multB = 8'($urandom);
      start = (interfere && k == 4) ? 1'b1 : 1'b0;
      step();
      start = 1'b0;
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      chk("product_held", 32'(product), 32'(last_prod));
    end
    step();                       // edge 10: SIGN
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("product", 32'(product), 32'(exp));
    last_prod = exp;
    step();                       // edge 11: back to IDLE
    chk("done_cleared", 32'(done), 32'd0);
    step();                       // a queued start would show busy here
    chk("idle_busy", 32'(busy), 32'd0);
    chk("product_kept", 32'(product), 32'(exp));
  endtask

  initial begin
    // Reset with a start request present: must be ignored.
    rst   = 1'b1;
    start = 1'b1;
    multA = 8'd3;
    multB = 8'd4;
    step();
    step();
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);

    run_mult(8'd7, 8'd6, 1'b0);
    run_mult(8'h80, 8'h80, 1'b0);
    run_mult(8'h80, 8'h7F, 1'b0);
    run_mult(8'hFB, 8'h00, 1'b0);
    run_mult(8'hFF, 8'hFF, 1'b0);
    run_mult(8'd100, 8'hC5, 1'b1);

    // Abort at cycle 5 of a run.
    multA = 8'd9;
    multB = 8'hF3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    last_prod = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run_mult(8'hF6, 8'd12, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_mult(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/signed_mult_seq.md
# signed_mult_seq

Sequential 8x8 signed (two's-complement) multiplier controller for the multiplier datapath. It latches two signed operands on a start request and converts negative operands to magnitudes with two's-complement negation (~x + 1). It then runs an unsigned shift-add loop, one operand bit per cycle, and negates the 16-bit result when the operand signs differ. A start/busy/done handshake lets one upstream requester issue one multiplication at a time.

## Interface
Parameters:
- WIDTH, 8, operand width in bits. Product width is 2*WIDTH. The test plan uses WIDTH=8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- start  input  1  request to begin a multiplication. Accepted only in IDLE.
- multA  input  WIDTH  signed multiplicand, sampled on the accepting edge.
- multB  input  WIDTH  signed multiplier, sampled on the accepting edge.
- product  output  2*WIDTH  registered signed result. Valid while done=1 and held until the next accepted start.
- busy  output  1  high in states ABS, LOOP and SIGN.
- done  output  1  one-cycle pulse, high in state DONE.

## Operation
- The block uses one clock, with a synchronous active-high reset (rst) sampled on the rising edge of clk.
- Reset forces state=IDLE, product=0, busy=0, done=0, and clears the internal magnitude and accumulator registers and the bit counter.
- States and transitions:
  - IDLE: on start=1, latch multA and multB, record sign = multA[MSB] XOR multB[MSB], go to ABS. Otherwise stay in IDLE.
  - ABS: replace each negative operand with its two's complement (~x+1), truncated to WIDTH bits and treated as unsigned. Clear the 2*WIDTH accumulator, clear the counter, go to LOOP.
  - LOOP: each cycle, if the multiplier magnitude LSB is 1, add the zero-extended, left-shifted multiplicand magnitude to the accumulator. Then shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter. After WIDTH iterations, go to SIGN.
  - SIGN: if sign=1, product = ~acc + 1 (2*WIDTH bits); otherwise product = acc. Go to DONE.
  - DONE: done=1 for this cycle only. Go to IDLE unconditionally.
- Arithmetic rules:
  - The magnitude of the most negative input (-2^(WIDTH-1)) is 2^(WIDTH-1). This is representable as unsigned and must not saturate.
  - The maximum magnitude product, 2^(2*WIDTH-2), fits in 2*WIDTH bits, so no overflow is possible.
  - Negating a zero accumulator yields 0.
- Boundary conditions:
  - start while busy=1 or in DONE is ignored. It is not queued; the requester must reassert start in IDLE.
  - Operand changes after the accepting edge have no effect on the running operation.
  - rst=1 in any state aborts the operation. The next edge applies the reset values, including product=0; no done pulse is produced.
  - rst and start both high: reset wins.

## Timing
- Edge 0: start sampled in IDLE. busy goes 1 after this edge.
- Edge 1: ABS executes.
- Edges 2..WIDTH+1: LOOP iterations (8 for WIDTH=8).
- Edge WIDTH+2 (edge 10): SIGN loads product. After this edge busy=0 and done=1.
- Edge WIDTH+3: done returns to 0 and state is IDLE. The earliest next accepted start is on this edge's following cycle, giving one multiplication per WIDTH+4 cycles.
- Latency from the accepting edge to done high is WIDTH+2 = 10 cycles.
- product changes only on the SIGN edge and on reset.

## Test plan
- Reset, then hold rst=1 for 2 cycles -> product=0x0000, busy=0, done=0. start=1 during reset is ignored.
- multA=7, multB=6, start pulse -> done pulses exactly 10 cycles after the accepting edge, product=0x002A, and busy is high for cycles 1..9.
- multA=-128 (0x80), multB=-128 -> product=0x4000. multA=-128, multB=127 -> product=0xC080 (-16256).
- multA=-5, multB=0 -> product=0x0000. multA=-1, multB=-1 -> product=0x0001.
- Pulse start again at cycle 4 of a run with different operands, and change multA mid-run -> the first result is unaffected, and the second start is not executed.
- Assert rst at cycle 5 of a run -> after the next edge product=0, busy=0, done=0. No done pulse occurs, and a fresh start then completes normally with the correct product.
